biu_bus_arbiter: RTL and testbench
==================================

# biu_bus_arbiter

Two-master arbiter and bus launcher inside the BIU, directly downstream of the instruction- and data-side CPU bus sub-interfaces. It grants one sub-interface at a time via its chip-select, waits for that sub-interface's strobe, and runs a single-beat transfer on the shared system bus. It returns a one-cycle acknowledge with registered read data, and aborts with an error after a programmable timeout.

## Interface
- TIMEOUT, 255: max BUS-state cycles before abort (1..255, 8-bit counter)
- clk_i  in  1  system clock, rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- m0_req_i / m1_req_i  in  1  request from data (m0) / instruction (m1) sub-interface
- m0_stb_i / m1_stb_i  in  1  strobe from sub-interface (registered there)
- m0_we_i, m1_we_i  in  1  write enable (m1 ignored, always read)
- m0_adr_i / m1_adr_i  in  32  byte address
- m0_sel_i  in  4  byte lanes for m0 (m1 uses 4'hF)
- m0_dat_i  in  32  write data for m0
- m0_cs_o / m1_cs_o  out  1  grant/chip-select to each sub-interface
- bus_ack_o  out  1  one-cycle completion pulse, shared by both sub-interfaces
- bus_dat_o  out  32  read data valid with bus_ack_o
- bus_err_o  out  1  one-cycle pulse with bus_ack_o on timeout abort
- wb_cyc_o, wb_stb_o  out  1  system bus cycle/strobe (always equal)
- wb_we_o  out  1;  wb_adr_o  out  32;  wb_sel_o  out  4;  wb_dat_o  out  32
- wb_dat_i  in  32;  wb_ack_i  in  1  slave read data / acknowledge

## Operation
- States: IDLE, GRANT, BUS, ACK. All outputs registered.
- IDLE: if any req_i is high, pick a winner and go to GRANT, setting winner's cs_o. Single request wins directly. When both are requesting, the master not granted last wins (round-robin). The last-grant flag resets to m1, so m0 wins the first tie.
- GRANT: winner cs_o held high. If winner stb_i is high, capture adr/we/sel/dat (m1: we=0, sel=F, dat=0), assert wb_cyc_o/wb_stb_o, clear the timeout counter, and go to BUS. If winner req_i drops before stb_i, drop cs_o and return to IDLE.
- BUS: hold all wb_* outputs stable. The counter increments each cycle.
  - On wb_ack_i: register wb_dat_i into bus_dat_o, pulse bus_ack_o, drop wb_cyc_o/wb_stb_o, go to ACK.
  - On counter == TIMEOUT-1 without ack: abort. Drop cyc/stb, bus_dat_o=0, pulse bus_ack_o and bus_err_o, go to ACK.
  - If ack and timeout coincide, ack wins and bus_err_o stays 0.
- ACK: bus_ack_o high exactly this cycle, with winner cs_o still high so the sub-interface latches data. Next edge: cs_o low, bus_ack_o/bus_err_o low, update last-grant, go to IDLE.
- Requests from the non-winner are ignored until IDLE. cs_o is never high for both masters.
- wb_ack_i outside BUS is ignored.
- Reset (async, any state): state=IDLE, both cs_o=0, bus_ack_o=0, bus_err_o=0, bus_dat_o=0, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=0, wb_sel_o=0, wb_dat_o=0, counter=0, last-grant=m1. A transfer in flight is dropped without ack.

## Timing
- Edge 0: req seen in IDLE. Edge 1: cs_o high. The sub-interface raises stb the following edge.
- GRANT→BUS on the edge where stb_i is seen. wb_cyc_o high from that edge.
- Zero-wait slave (wb_ack_i in first BUS cycle): bus_ack_o high on the next cycle. Total 5 edges from req to IDLE with single-cycle stb response.
- bus_ack_o is high exactly one cycle per transfer. There is no back-to-back grant: minimum 1 IDLE cycle between transfers.
- Timeout: bus_err_o asserts TIMEOUT cycles after entering BUS.

## Test plan
- m0 read, adr 0x0000_1000, slave acks first BUS cycle with 0xCAFEBABE -> wb_adr_o=0x1000, wb_we_o=0, sel=F; bus_ack_o one cycle with bus_dat_o=0xCAFEBABE, m0_cs_o high in that cycle, bus_err_o=0.
- m0 write 0x12345678 to 0x2000, sel=4'b0011, slave waits 3 cycles -> wb_we_o=1, wb_dat_o=0x12345678, wb_sel_o=3, bus stable 4 BUS cycles, single bus_ack_o pulse.
- m0 and m1 requesting in the same cycle, repeatedly -> grants alternate m0, m1, m0, m1; cs_o never both high.
- m1 requests then drops req_i in GRANT before stb -> m1_cs_o falls, IDLE, no wb_cyc_o.
- No slave ack, TIMEOUT=8 -> cyc drops after 8 BUS cycles; bus_ack_o=bus_err_o=1 for one cycle, bus_dat_o=0. Ack arriving on the timeout cycle -> bus_err_o=0.
- rst_n_i low mid-BUS -> all outputs at reset values immediately (asynchronously). After release, a new m1 request completes normally.

Source files
------------

// File: rtl/biu_bus_arbiter.sv
// biu_bus_arbiter: grants the data (m0) or instruction (m1) sub-interface,
// runs one single-beat transfer on the system bus, then acks or times out.
module biu_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        m0_req_i,
    input  logic        m1_req_i,
    input  logic        m0_stb_i,
    input  logic        m1_stb_i,
    input  logic        m0_we_i,
    input  logic        m1_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m1_adr_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_cs_o,
    output logic        m1_cs_o,
    output logic        bus_ack_o,
    output logic [31:0] bus_dat_o,
    output logic        bus_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GRANT, BUS, ACK} state_t;

    state_t        state_q, state_d;
    logic          win_q, win_d;      // 0 = m0, 1 = m1
    logic          last_q, last_d;    // master granted last
    logic [CW-1:0] cnt_q, cnt_d;
    logic          m0_cs_q, m0_cs_d, m1_cs_q, m1_cs_d;
    logic          ack_q, ack_d, err_q, err_d;
    logic [31:0]   rdat_q, rdat_d;
    logic          cyc_q, cyc_d, we_q, we_d;
    logic [31:0]   adr_q, adr_d, dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic          pick;
    logic          win_req, win_stb;

    assign win_req = win_q ? m1_req_i : m0_req_i;
    assign win_stb = win_q ? m1_stb_i : m0_stb_i;

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            m0_cs_q <= 1'b0;
            m1_cs_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            m0_cs_q <= m0_cs_d;
            m1_cs_q <= m1_cs_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        m0_cs_d = m0_cs_q;
        m1_cs_d = m1_cs_q;
        ack_d   = ack_q;
        err_d   = err_q;
        rdat_d  = rdat_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        pick    = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    // On a tie the master not granted last wins
                    pick    = (m0_req_i && m1_req_i) ? ~last_q : m1_req_i;
                    win_d   = pick;
                    m0_cs_d = ~pick;
                    m1_cs_d = pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (win_stb) begin
                    if (win_q) begin
                        // m1 is fetch-only: its we is tied off
                        adr_d = m1_adr_i;
                        we_d  = 1'b0 & m1_we_i;
                        sel_d = 4'hF;
                        dat_d = '0;
                    end else begin
                        adr_d = m0_adr_i;
                        we_d  = m0_we_i;
                        sel_d = m0_sel_i;
                        dat_d = m0_dat_i;
                    end
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = BUS;
                end else if (!win_req) begin
                    m0_cs_d = 1'b0;
                    m1_cs_d = 1'b0;
                    state_d = IDLE;
                end
            end
            BUS: begin
                cnt_d = cnt_q + CW'(1);
                if (wb_ack_i) begin
                    rdat_d  = wb_dat_i;
                    ack_d   = 1'b1;
                    cyc_d   = 1'b0;
                    state_d = ACK;
                end else if (cnt_q == CNT_LAST) begin
                    rdat_d  = '0;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    cyc_d   = 1'b0;
                    state_d = ACK;
                end
            end
            ACK: begin
                m0_cs_d = 1'b0;
                m1_cs_d = 1'b0;
                ack_d   = 1'b0;
                err_d   = 1'b0;
                last_d  = win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign m0_cs_o   = m0_cs_q;
    assign m1_cs_o   = m1_cs_q;
    assign bus_ack_o = ack_q;
    assign bus_err_o = err_q;
    assign bus_dat_o = rdat_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign wb_we_o   = we_q;
    assign wb_adr_o  = adr_q;
    assign wb_sel_o  = sel_q;
    assign wb_dat_o  = dat_q;

endmodule

// File: tb/tb_biu_bus_arbiter.sv
// Bench for biu_bus_arbiter: transaction-level reference model of grant order,
// captured payload, BUS length, completion data and timeout error.
module tb_biu_bus_arbiter;

    localparam int unsigned TO = 8;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        m0_req_i, m1_req_i, m0_stb_i, m1_stb_i, m0_we_i, m1_we_i;
    logic [31:0] m0_adr_i, m1_adr_i, m0_dat_i, wb_dat_i;
    logic [3:0]  m0_sel_i;
    logic        wb_ack_i;
    logic        m0_cs_o, m1_cs_o, bus_ack_o, bus_err_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] bus_dat_o, wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;

    int checks = 0;
    int errors = 0;
    int exp_last = 1;

    typedef struct packed {
        logic        hung;
        logic [1:0]  win;
        logic        both_cs;
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        stable;
        logic [8:0]  nbus;
        logic [3:0]  ackcnt;
        logic [31:0] ack_dat;
        logic        ack_err;
        logic        cs_at_ack;
        logic [4:0]  tail;
    } obs_t;

    always #5 clk_i = ~clk_i;

    biu_bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .m0_req_i(m0_req_i), .m1_req_i(m1_req_i),
        .m0_stb_i(m0_stb_i), .m1_stb_i(m1_stb_i),
        .m0_we_i(m0_we_i), .m1_we_i(m1_we_i),
        .m0_adr_i(m0_adr_i), .m1_adr_i(m1_adr_i),
        .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
        .m0_cs_o(m0_cs_o), .m1_cs_o(m1_cs_o),
        .bus_ack_o(bus_ack_o), .bus_dat_o(bus_dat_o), .bus_err_o(bus_err_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    // Reference: what one transfer should look like, from the arbitration rules
    function automatic obs_t model(input bit r0, input bit r1, input logic we,
                                   input logic [31:0] adr, input logic [3:0] sel,
                                   input logic [31:0] dat, input int ack_wait,
                                   input logic [31:0] rdata);
        obs_t e;
        int   w;
        bit   timed;
        e = '0;
        if (r0 && r1) w = (exp_last == 1) ? 0 : 1;
        else          w = r0 ? 0 : 1;
        e.win = 2'(w);
        if (w == 0) begin
            e.adr = adr; e.we = we; e.sel = sel; e.dat = dat;
        end else begin
            e.adr = ~adr; e.we = 1'b0; e.sel = 4'hF; e.dat = 32'h0;
        end
        timed       = (ack_wait + 1) > int'(TO);
        e.stable    = 1'b1;
        e.nbus      = timed ? 9'(TO) : 9'(ack_wait + 1);
        e.ackcnt    = 4'd1;
        e.ack_dat   = timed ? 32'h0 : rdata;
        e.ack_err   = timed;
        e.cs_at_ack = 1'b1;
        return e;
    endfunction

    // Plays both sub-interfaces and the slave for one transfer, recording what it sees
    task automatic run_xfer(input bit r0, input bit r1, input logic we,
                            input logic [31:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat, input int ack_wait,
                            input logic [31:0] rdata, output obs_t o);
        o = '0;
        o.win = 2'b11;
        m0_req_i = r0; m1_req_i = r1;
        m0_we_i = we; m1_we_i = ~we;
        m0_adr_i = adr; m1_adr_i = ~adr;
        m0_sel_i = sel; m0_dat_i = dat;
        for (int i = 0; i < 6 && o.win == 2'b11; i++) begin
            @(posedge clk_i); #1;
            if (m0_cs_o && m1_cs_o) o.both_cs = 1'b1;
            if (bus_ack_o) o.ackcnt = o.ackcnt + 4'd1;
            if (m0_cs_o) o.win = 2'd0;
            else if (m1_cs_o) o.win = 2'd1;
        end
        if (o.win == 2'b11) begin
            o.hung = 1'b1; m0_req_i = 1'b0; m1_req_i = 1'b0;
            return;
        end
        if (o.win == 2'd0) m0_stb_i = 1'b1; else m1_stb_i = 1'b1;
        @(posedge clk_i); #1;
        m0_stb_i = 1'b0; m1_stb_i = 1'b0;
        if (!wb_cyc_o) begin
            o.hung = 1'b1; m0_req_i = 1'b0; m1_req_i = 1'b0;
            @(posedge clk_i); #1;
            return;
        end
        o.adr = wb_adr_o; o.we = wb_we_o; o.sel = wb_sel_o; o.dat = wb_dat_o;
        o.stable = 1'b1;
        while (wb_cyc_o && o.nbus < 9'd300) begin
            o.nbus = o.nbus + 9'd1;
            if (m0_cs_o && m1_cs_o) o.both_cs = 1'b1;
            if (bus_ack_o) o.ackcnt = o.ackcnt + 4'd1;
            if ({wb_adr_o, wb_we_o, wb_sel_o, wb_dat_o, wb_stb_o} !==
                {o.adr, o.we, o.sel, o.dat, 1'b1}) o.stable = 1'b0;
            if (int'(o.nbus) == ack_wait + 1) begin
                wb_ack_i = 1'b1; wb_dat_i = rdata;
            end
            @(posedge clk_i); #1;
            wb_ack_i = 1'b0; wb_dat_i = $urandom;
        end
        if (wb_cyc_o) begin
            o.hung = 1'b1;
            return;
        end
        if (bus_ack_o) o.ackcnt = o.ackcnt + 4'd1;
        o.ack_dat   = bus_dat_o;
        o.ack_err   = bus_err_o;
        o.cs_at_ack = (o.win == 2'd0) ? (m0_cs_o && !m1_cs_o) : (m1_cs_o && !m0_cs_o);
        wb_ack_i = 1'b1;   // stray slave ack outside BUS must be ignored
        @(posedge clk_i); #1;
        wb_ack_i = 1'b0;
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        o.tail = {m0_cs_o, m1_cs_o, bus_ack_o, bus_err_o, wb_cyc_o};
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if ({m0_cs_o, m1_cs_o, bus_ack_o, bus_err_o, bus_dat_o, wb_cyc_o, wb_stb_o,
             wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o} !== '0) begin
            errors++;
            $display("FAIL reset_values: got cs=%b%b ack=%b err=%b cyc=%b adr=%h dat=%h want all zero",
                     m0_cs_o, m1_cs_o, bus_ack_o, bus_err_o, wb_cyc_o, wb_adr_o, wb_dat_o);
        end
        rst_n_i = 1'b1;
        exp_last = 1;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if ({m0_cs_o, m1_cs_o, bus_ack_o, wb_cyc_o} !== 4'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got cs=%b%b ack=%b cyc=%b want 0000",
                     m0_cs_o, m1_cs_o, bus_ack_o, wb_cyc_o);
        end
    endtask

    task automatic test_round_robin();
        obs_t o, e;
        for (int i = 0; i < 6; i++) begin
            e = model(1'b1, 1'b1, 1'b0, 32'h0000_0100 * (i + 1), 4'hF, 32'h0, i % 2, 32'hA000_0000 + i);
            run_xfer(1'b1, 1'b1, 1'b0, 32'h0000_0100 * (i + 1), 4'hF, 32'h0, i % 2, 32'hA000_0000 + i, o);
            exp_last = int'(e.win);
            checks++;
            if ({o.hung, o.win, o.both_cs} !== {e.hung, e.win, e.both_cs}) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got win=%0d hung=%b both_cs=%b want win=%0d",
                         i, o.win, o.hung, o.both_cs, e.win);
            end
            checks++;
            if ({o.adr, o.ackcnt, o.ack_dat, o.ack_err, o.tail} !==
                {e.adr, e.ackcnt, e.ack_dat, e.ack_err, e.tail}) begin
                errors++;
                $display("FAIL rr_done[%0d]: got adr=%h acks=%0d dat=%h err=%b tail=%b want adr=%h acks=%0d dat=%h err=%b",
                         i, o.adr, o.ackcnt, o.ack_dat, o.ack_err, o.tail, e.adr, e.ackcnt, e.ack_dat, e.ack_err);
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] adr_t [5];
        logic [31:0] dat_t [5];
        logic [31:0] rd_t  [5];
        logic [3:0]  sel_t [5];
        logic        we_t  [5];
        int          wt_t  [5];
        bit          r1_t  [5];
        obs_t o, e;
        adr_t = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_4000, 32'h0000_5000};
        dat_t = '{32'h0, 32'h1234_5678, 32'h0, 32'h0, 32'h0};
        rd_t  = '{32'hCAFE_BABE, 32'h0, 32'hDEAD_BEEF, 32'h5A5A_1234, 32'h7777_0001};
        sel_t = '{4'hF, 4'b0011, 4'hF, 4'hF, 4'h1};
        we_t  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        wt_t  = '{0, 3, 20, 7, 1};
        r1_t  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            e = model(!r1_t[i], r1_t[i], we_t[i], adr_t[i], sel_t[i], dat_t[i], wt_t[i], rd_t[i]);
            run_xfer(!r1_t[i], r1_t[i], we_t[i], adr_t[i], sel_t[i], dat_t[i], wt_t[i], rd_t[i], o);
            exp_last = int'(e.win);
            checks++;
            if ({o.hung, o.win, o.both_cs} !== {e.hung, e.win, e.both_cs}) begin
                errors++;
                $display("FAIL dir_grant[%0d]: got win=%0d hung=%b both_cs=%b want win=%0d",
                         i, o.win, o.hung, o.both_cs, e.win);
            end
            checks++;
            if ({o.adr, o.we, o.sel, o.dat, o.stable, o.nbus} !==
                {e.adr, e.we, e.sel, e.dat, e.stable, e.nbus}) begin
                errors++;
                $display("FAIL dir_bus[%0d]: got adr=%h we=%b sel=%h dat=%h stable=%b nbus=%0d want adr=%h we=%b sel=%h dat=%h stable=1 nbus=%0d",
                         i, o.adr, o.we, o.sel, o.dat, o.stable, o.nbus, e.adr, e.we, e.sel, e.dat, e.nbus);
            end
            checks++;
            if ({o.ackcnt, o.ack_dat, o.ack_err, o.cs_at_ack, o.tail} !==
                {e.ackcnt, e.ack_dat, e.ack_err, e.cs_at_ack, e.tail}) begin
                errors++;
                $display("FAIL dir_done[%0d]: got acks=%0d dat=%h err=%b cs_at_ack=%b tail=%b want acks=%0d dat=%h err=%b cs_at_ack=1 tail=0",
                         i, o.ackcnt, o.ack_dat, o.ack_err, o.cs_at_ack, o.tail, e.ackcnt, e.ack_dat, e.ack_err);
            end
        end
    endtask

    task automatic test_drop_req();
        bit got_cs = 1'b0;
        bit bad    = 1'b0;
        m1_req_i = 1'b1; m1_adr_i = 32'h0000_9000;
        for (int i = 0; i < 6 && !got_cs; i++) begin
            @(posedge clk_i); #1;
            got_cs = m1_cs_o;
        end
        checks++;
        if (got_cs !== 1'b1) begin
            errors++;
            $display("FAIL drop_grant: got m1_cs=%b want 1", got_cs);
        end
        m1_req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i); #1;
            if (m0_cs_o || m1_cs_o || wb_cyc_o || bus_ack_o) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL drop_release: got activity=%b want 0 (cs/cyc/ack stay low)", bad);
        end
    endtask

    task automatic test_random();
        obs_t o, e;
        int   p, wt;
        logic we;
        logic [31:0] adr, dat, rd;
        logic [3:0]  sel;
        for (int i = 0; i < 40; i++) begin
            p   = $urandom_range(1, 3);
            wt  = $urandom_range(0, 10);
            we  = 1'($urandom);
            adr = $urandom; dat = $urandom; rd = $urandom;
            sel = 4'($urandom);
            e = model(p[0], p[1], we, adr, sel, dat, wt, rd);
            run_xfer(p[0], p[1], we, adr, sel, dat, wt, rd, o);
            exp_last = int'(e.win);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rand[%0d]: req=%0d wait=%0d got %h want %h", i, p, wt, o, e);
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t o, e;
        bit got_cs = 1'b0;
        m0_req_i = 1'b1; m0_we_i = 1'b1; m0_adr_i = 32'h0000_ABC0;
        m0_sel_i = 4'hF; m0_dat_i = 32'h1111_2222;
        for (int i = 0; i < 6 && !got_cs; i++) begin
            @(posedge clk_i); #1;
            got_cs = m0_cs_o || m1_cs_o;
        end
        if (m0_cs_o) m0_stb_i = 1'b1; else m1_stb_i = 1'b1;
        @(posedge clk_i); #1;
        m0_stb_i = 1'b0; m1_stb_i = 1'b0;
        checks++;
        if (wb_cyc_o !== 1'b1) begin
            errors++;
            $display("FAIL arst_in_bus: got cyc=%b want 1", wb_cyc_o);
        end
        @(posedge clk_i); #3;
        rst_n_i = 1'b0;
        #1;
        checks++;
        if ({m0_cs_o, m1_cs_o, bus_ack_o, bus_err_o, bus_dat_o, wb_cyc_o, wb_stb_o,
             wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o} !== '0) begin
            errors++;
            $display("FAIL arst_values: got cs=%b%b ack=%b cyc=%b we=%b adr=%h sel=%h dat=%h want all zero",
                     m0_cs_o, m1_cs_o, bus_ack_o, wb_cyc_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o);
        end
        m0_req_i = 1'b0;
        @(posedge clk_i); #2;
        rst_n_i = 1'b1;
        exp_last = 1;
        @(posedge clk_i); #1;
        e = model(1'b0, 1'b1, 1'b0, 32'h0F0F_0000, 4'hF, 32'h0, 2, 32'hBEEF_0042);
        run_xfer(1'b0, 1'b1, 1'b0, 32'h0F0F_0000, 4'hF, 32'h0, 2, 32'hBEEF_0042, o);
        exp_last = int'(e.win);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL arst_after: got %h want %h", o, e);
        end
    endtask

    initial begin
        rst_n_i = 1'b0;
        m0_req_i = 1'b0; m1_req_i = 1'b0; m0_stb_i = 1'b0; m1_stb_i = 1'b0;
        m0_we_i = 1'b0; m1_we_i = 1'b0; m0_adr_i = '0; m1_adr_i = '0;
        m0_sel_i = '0; m0_dat_i = '0; wb_dat_i = '0; wb_ack_i = 1'b0;
        test_reset();
        test_round_robin();
        test_directed();
        test_drop_req();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
